// File: rtl/ram_burst_pkg.sv
// -----------------------------------------------------------------------------
// ram_burst_pkg
// Shared definitions for the RAM burst master: FSM state encoding, beat
// geometry and the byte-strobe to bit-mask expansion helper.
// -----------------------------------------------------------------------------
package ram_burst_pkg;

  // One RAM index addresses one 64-bit beat of 8 bytes.
  localparam int BEAT_BYTES = 8;
  localparam int IDX_SHIFT  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Each strobe bit enables all eight bits of its byte lane.
  function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/ram_burst_rd_stage.sv
// -----------------------------------------------------------------------------
// ram_burst_rd_stage
// One-entry valid/ready output register for read beats. Holds data/last
// stable while the consumer stalls and tells the issuer when a new beat
// may be loaded.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_load        load i_data/i_last into the register this cycle
//   i_data        beat data to load
//   i_last        last-beat flag to load
//   i_ready       consumer accepts the held beat
//   o_valid       register holds a beat
//   o_data        held beat data
//   o_last        held last-beat flag
//   o_can_load    register is empty or is being drained this cycle
// -----------------------------------------------------------------------------
module ram_burst_rd_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [63:0] i_data,
  input  logic        i_last,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [63:0] o_data,
  output logic        o_last,
  output logic        o_can_load
);

  logic        r_valid;
  logic [63:0] r_data;
  logic        r_last;

  assign o_can_load = !r_valid || i_ready;

  // NOTE: the data register is reset too, so the read data port shows a
  // defined zero after reset rather than a stale beat.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/ram_burst_master.sv
// -----------------------------------------------------------------------------
// ram_burst_master
// Converts byte-addressed read/write bursts into per-beat accesses on the
// 64-bit simulation RAM helper port.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        burst request handshake (ready only in IDLE)
//   req_write, req_addr,       direction, byte address (low 3 bits ignored),
//   req_len                    beats minus one
//   w_valid/w_ready, w_data,   write beat channel with byte strobes
//   w_strb
//   b_valid/b_ready            write burst completion
//   r_valid/r_ready, r_data,   registered, back-pressurable read beats
//   r_last
//   ram_en, ram_rIdx,          RAM access enable, read index, comb read data
//   ram_rdata
//   ram_wIdx, ram_wdata,       RAM write index/data/bit mask/enable; zero
//   ram_wmask, ram_wen         outside write-issue cycles
// -----------------------------------------------------------------------------
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [63:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [63:0]      w_data,
  input  logic [7:0]       w_strb,
  output logic             b_valid,
  input  logic             b_ready,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [63:0]      r_data,
  output logic             r_last,
  output logic             ram_en,
  output logic [63:0]      ram_rIdx,
  input  logic [63:0]      ram_rdata,
  output logic [63:0]      ram_wIdx,
  output logic [63:0]      ram_wdata,
  output logic [63:0]      ram_wmask,
  output logic             ram_wen
);

  state_t           r_state;
  logic [63:0]      r_idx;   // beat index, wraps modulo 2^64
  logic [LEN_W-1:0] r_cnt;   // beats remaining minus one

  logic w_can_load;
  logic w_rd_issue;
  logic w_wr_beat;
  logic w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);
  // A read beat issues only when the output register can take it, which
  // also holds off a new burst until the previous burst's last beat drains.
  assign w_rd_issue = (r_state == ST_READ) && w_can_load;
  assign w_wr_beat  = (r_state == ST_WRITE) && w_valid;

  // The counter is never decremented past zero in a way that is observed:
  // the beat issued at zero leaves the data state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_idx   <= req_addr >> IDX_SHIFT;
            r_cnt   <= req_len;
            r_state <= req_write ? ST_WRITE : ST_READ;
          end
        end
        ST_READ: begin
          if (w_rd_issue) begin
            r_idx <= r_idx + 64'd1;
            r_cnt <= r_cnt - LEN_W'(1);
            if (w_cnt_zero) r_state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (w_wr_beat) begin
            r_idx <= r_idx + 64'd1;
            r_cnt <= r_cnt - LEN_W'(1);
            if (w_cnt_zero) r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (b_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs decode directly from the state register.
  assign req_ready = (r_state == ST_IDLE);
  assign w_ready   = (r_state == ST_WRITE);
  assign b_valid   = (r_state == ST_RESP);

  // RAM port: read index is always presented; write fields are zeroed when
  // no write beat issues so idle cycles show a quiet bus.
  assign ram_en    = w_rd_issue || w_wr_beat;
  assign ram_wen   = w_wr_beat;
  assign ram_rIdx  = r_idx;
  assign ram_wIdx  = w_wr_beat ? r_idx : '0;
  assign ram_wdata = w_wr_beat ? w_data : '0;
  assign ram_wmask = w_wr_beat ? strb_to_mask(w_strb) : '0;

  ram_burst_rd_stage u_rd_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_rd_issue),
    .i_data     (ram_rdata),
    .i_last     (w_cnt_zero),
    .i_ready    (r_ready),
    .o_valid    (r_valid),
    .o_data     (r_data),
    .o_last     (r_last),
    .o_can_load (w_can_load)
  );

endmodule

// File: tb/tb_ram_burst_master.sv
// -----------------------------------------------------------------------------
// tb_ram_burst_master
// Directed bench for ram_burst_master. The RAM read side returns index*0x11
// combinationally; committed writes are logged on the clock edge.
// -----------------------------------------------------------------------------
module tb_ram_burst_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [7:0]  req_len;
  logic        w_valid;
  logic        w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_valid;
  logic        b_ready;
  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic        r_last;
  logic        ram_en;
  logic [63:0] ram_rIdx;
  logic [63:0] ram_rdata;
  logic [63:0] ram_wIdx;
  logic [63:0] ram_wdata;
  logic [63:0] ram_wmask;
  logic        ram_wen;

  int total = 0;
  int bad   = 0;

  int          wcount = 0;
  logic [63:0] wlog_idx  [16];
  logic [63:0] wlog_data [16];
  logic [63:0] wlog_mask [16];

  ram_burst_master #(.LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_strb    (w_strb),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_data    (r_data),
    .r_last    (r_last),
    .ram_en    (ram_en),
    .ram_rIdx  (ram_rIdx),
    .ram_rdata (ram_rdata),
    .ram_wIdx  (ram_wIdx),
    .ram_wdata (ram_wdata),
    .ram_wmask (ram_wmask),
    .ram_wen   (ram_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: preloaded contents are index * 0x11.
  assign ram_rdata = ram_rIdx * 64'h11;

  always @(posedge clk) begin
    if (ram_en && ram_wen) begin
      wlog_idx[wcount[3:0]]  <= ram_wIdx;
      wlog_data[wcount[3:0]] <= ram_wdata;
      wlog_mask[wcount[3:0]] <= ram_wmask;
      wcount <= wcount + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Present a request for one cycle; leaves the bench just after the
  // accepting edge.
  task automatic send_req(input logic wr, input logic [63:0] addr, input logic [7:0] len);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_len   = len;
    settle();
    check("req_ready_before_accept", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
  endtask

  logic [63:0] held;
  logic        stalled;
  int          beat;
  int          wbase;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    w_valid   = 1'b0;
    w_data    = '0;
    w_strb    = '0;
    b_ready   = 1'b0;
    r_ready   = 1'b0;
    #3;
    check("rst_r_valid", r_valid, 1'b0);
    check("rst_r_last",  r_last,  1'b0);
    check("rst_b_valid", b_valid, 1'b0);
    check("rst_r_data",  r_data,  64'h0);
    check("rst_ram_en",  ram_en,  1'b0);
    check("rst_ram_wen", ram_wen, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_req_ready", req_ready, 1'b1);

    // ---- Read burst 0x1008, len 3, r_ready held high ----
    r_ready = 1'b1;
    send_req(1'b0, 64'h1008, 8'd3);
    check("rd_r_valid_latency", r_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      settle();
      check("rd_ram_en",   ram_en,   1'b1);
      check("rd_ram_rIdx", ram_rIdx, 64'h201 + 64'(k));
      step();
      check("rd_r_valid", r_valid, 1'b1);
      check("rd_r_data",  r_data,  64'h2211 + 64'h11 * 64'(k));
      check("rd_r_last",  r_last,  k == 3);
    end
    check("rd_done_req_ready", req_ready, 1'b1);
    step();
    check("rd_drained", r_valid, 1'b0);

    // ---- Same read with r_ready pattern 1,0,0,1 ----
    send_req(1'b0, 64'h1008, 8'd3);
    beat = 0;
    for (int cyc = 0; cyc < 40 && beat < 4; cyc++) begin
      r_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      settle();
      stalled = r_valid && !r_ready;
      held    = r_data;
      if (stalled) check("stall_ram_en", ram_en, 1'b0);
      if (r_valid && r_ready) begin
        check("stall_r_data", r_data, 64'h2211 + 64'h11 * 64'(beat));
        check("stall_r_last", r_last, beat == 3);
        beat++;
      end
      step();
      if (stalled) check("stall_hold", r_data, held);
    end
    check("stall_beat_count", 64'(beat), 64'd4);
    r_ready = 1'b1;
    step();
    check("stall_drained", r_valid, 1'b0);

    // ---- Write burst 0x40, len 1 ----
    w_valid = 1'b1;
    w_strb  = 8'hFF;
    settle();
    check("idle_w_ready", w_ready, 1'b0);
    check("idle_ram_wen", ram_wen, 1'b0);
    w_valid = 1'b0;
    wbase = wcount;
    send_req(1'b1, 64'h40, 8'd1);
    w_valid = 1'b1;
    w_data  = 64'hA5A5_0000_1111_2222;
    w_strb  = 8'h0F;
    settle();
    check("wr0_w_ready",   w_ready,   1'b1);
    check("wr0_ram_en",    ram_en,    1'b1);
    check("wr0_ram_wen",   ram_wen,   1'b1);
    check("wr0_ram_wIdx",  ram_wIdx,  64'h8);
    check("wr0_ram_wmask", ram_wmask, 64'h0000_0000_FFFF_FFFF);
    check("wr0_ram_wdata", ram_wdata, 64'hA5A5_0000_1111_2222);
    step();
    w_data = 64'h0123_4567_89AB_CDEF;
    w_strb = 8'hFF;
    settle();
    check("wr1_ram_wIdx",  ram_wIdx,  64'h9);
    check("wr1_ram_wmask", ram_wmask, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    w_valid = 1'b0;
    settle();
    check("wr_b_valid",     b_valid, 1'b1);
    check("wr_resp_wready", w_ready, 1'b0);
    check("wr_resp_ram_en", ram_en,  1'b0);
    check("wr_commits",     64'(wcount - wbase), 64'd2);
    check("wr_log0_idx",    wlog_idx[wbase % 16],        64'h8);
    check("wr_log0_mask",   wlog_mask[wbase % 16],       64'h0000_0000_FFFF_FFFF);
    check("wr_log1_data",   wlog_data[(wbase + 1) % 16], 64'h0123_4567_89AB_CDEF);
    step();
    check("wr_b_held",       b_valid,   1'b1);
    check("wr_b_req_ready",  req_ready, 1'b0);
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    check("wr_b_cleared",    b_valid,   1'b0);
    check("wr_end_req_ready", req_ready, 1'b1);

    // ---- Back-to-back: held 1-beat read, then a 2-beat read ----
    r_ready = 1'b0;
    send_req(1'b0, 64'h80, 8'd0);
    settle();
    check("b2b_first_rIdx", ram_rIdx, 64'h10);
    step();
    check("b2b_old_valid", r_valid, 1'b1);
    check("b2b_old_data",  r_data,  64'h110);
    check("b2b_old_last",  r_last,  1'b1);
    send_req(1'b0, 64'h100, 8'd1);
    settle();
    check("b2b_wait_ram_en", ram_en, 1'b0);
    check("b2b_wait_data",   r_data, 64'h110);
    step();
    check("b2b_wait_data2",  r_data, 64'h110);
    r_ready = 1'b1;
    settle();
    check("b2b_issue_en",   ram_en,   1'b1);
    check("b2b_issue_rIdx", ram_rIdx, 64'h20);
    step();
    check("b2b_new0_data", r_data, 64'h220);
    check("b2b_new0_last", r_last, 1'b0);
    step();
    check("b2b_new1_data", r_data, 64'h231);
    check("b2b_new1_last", r_last, 1'b1);
    step();
    check("b2b_drained", r_valid, 1'b0);

    // ---- Reset pulsed mid write burst (after beat 2 of 4) ----
    wbase = wcount;
    send_req(1'b1, 64'h200, 8'd3);
    for (int k = 0; k < 2; k++) begin
      w_valid = 1'b1;
      w_data  = 64'hDEAD_0000_0000_0000 + 64'(k);
      w_strb  = 8'hFF;
      step();
    end
    check("rst_mid_pre_commits", 64'(wcount - wbase), 64'd2);
    wbase = wcount;
    rst_n = 1'b0;
    settle();
    check("rst_mid_ram_wen",   ram_wen,   1'b0);
    check("rst_mid_ram_en",    ram_en,    1'b0);
    check("rst_mid_req_ready", req_ready, 1'b1);
    check("rst_mid_w_ready",   w_ready,   1'b0);
    check("rst_mid_b_valid",   b_valid,   1'b0);
    check("rst_mid_r_valid",   r_valid,   1'b0);
    check("rst_mid_r_data",    r_data,    64'h0);
    check("rst_mid_ram_wmask", ram_wmask, 64'h0);
    step();
    step();
    check("rst_mid_no_commit", 64'(wcount - wbase), 64'd0);
    rst_n   = 1'b1;
    w_valid = 1'b0;
    step();
    send_req(1'b0, 64'h1008, 8'd0);
    settle();
    check("rst_next_rIdx", ram_rIdx, 64'h201);
    step();
    check("rst_next_data", r_data, 64'h2211);
    check("rst_next_last", r_last, 1'b1);
    step();
    check("rst_next_drained", r_valid, 1'b0);
    check("rst_next_no_commit", 64'(wcount - wbase), 64'd0);

    // ---- Maximum burst: 256 beats from index 0 ----
    send_req(1'b0, 64'h0, 8'hFF);
    beat = 0;
    for (int cyc = 0; cyc < 300 && beat < 256; cyc++) begin
      step();
      if (r_valid) begin
        check("full_r_data", r_data, 64'h11 * 64'(beat));
        check("full_r_last", r_last, beat == 255);
        beat++;
      end
    end
    check("full_beat_count", 64'(beat), 64'd256);
    step();
    check("full_drained",   r_valid,   1'b0);
    check("full_req_ready", req_ready, 1'b1);

    // ---- 64-bit index wrap ----
    send_req(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 8'd1);
    settle();
    check("wrap_rIdx0", ram_rIdx, 64'h1FFF_FFFF_FFFF_FFFF);
    step();
    check("wrap_data0", r_data, 64'h1FFF_FFFF_FFFF_FFEF);
    check("wrap_rIdx1", ram_rIdx, 64'h2000_0000_0000_0000);
    step();
    check("wrap_data1", r_data, 64'h2000_0000_0000_0000);
    check("wrap_last1", r_last, 1'b1);
    step();
    check("wrap_drained", r_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Initiator-side bridge that drives the 64-bit simulation RAM helper port (`en`/`rIdx`/`rdata`/`wIdx`/`wdata`/`wmask`/`wen`) from a burst request interface with valid/ready read, write and write-response channels. It sits between a test master or bus adapter and the RAM model. It converts byte-addressed bursts into per-beat 8-byte index accesses. Read data is registered and back-pressurable; write strobes are expanded to bit masks.

## Interface
- `LEN_W`, 8, width of `req_len` (beats minus one); maximum burst is 2^LEN_W beats.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  burst request valid.
- `req_ready`  out  1  request accepted when both high.
- `req_write`  in  1  1 = write burst, 0 = read burst.
- `req_addr`  in  64  byte address; bits [2:0] ignored.
- `req_len`  in  LEN_W  beats minus one.
- `w_valid` / `w_ready`  in / out  1  write beat handshake.
- `w_data`  in  64  write beat data.
- `w_strb`  in  8  byte enables.
- `b_valid` / `b_ready`  out / in  1  write-burst completion handshake.
- `r_valid` / `r_ready`  out / in  1  read beat handshake.
- `r_data`  out  64  read beat data.
- `r_last`  out  1  final beat of the burst.
- `ram_en`  out  1  RAM access enable.
- `ram_rIdx`  out  64  RAM read index.
- `ram_rdata`  in  64  combinational RAM read data.
- `ram_wIdx`  out  64  RAM write index.
- `ram_wdata`  out  64  RAM write data.
- `ram_wmask`  out  64  RAM write bit mask.
- `ram_wen`  out  1  RAM write enable; the RAM commits on the `clk` edge when `ram_en && ram_wen`.

## Operation
- States: IDLE, READ, WRITE, RESP. `req_ready` = (state == IDLE).
- On accept, latch `idx = req_addr >> 3` and `cnt = req_len`, then go to READ or WRITE.
- READ
  - `ram_rIdx = idx` continuously.
  - A beat issues when `!r_valid || r_ready`.
  - On issue: `ram_en = 1`, `r_data <= ram_rdata`, `r_valid <= 1`, `r_last <= (cnt == 0)`, `idx++`, `cnt--`.
  - After the last issued beat, go to IDLE.
  - `r_valid` clears on `r_ready` with no new issue.
- WRITE
  - `w_ready = 1`.
  - On `w_valid`: `ram_en = ram_wen = 1`, `ram_wIdx = idx`, `ram_wdata = w_data`, `ram_wmask[8i+7:8i] = {8{w_strb[i]}}`, `idx++`, `cnt--`.
  - The beat at `cnt == 0` moves to RESP.
- RESP: `b_valid = 1`; go to IDLE on `b_ready`.
- Outside issuing cycles: `ram_en = ram_wen = 0`; `ram_wIdx`/`ram_wdata`/`ram_wmask` are don't-care but driven 0.
- `idx` is 64-bit and wraps modulo 2^64. No range check is done here.
- A new request may be accepted in IDLE while the previous burst's last read beat is still held in `r_data`. The new read's first beat waits for that slot to free.
- Write data arriving in IDLE/READ/RESP is not accepted (`w_ready = 0`).

## Timing
- Reset (asynchronous assert): state IDLE; `r_valid`, `r_last`, `b_valid`, `r_data` = 0; `req_ready` = 1 once reset is released. Any in-flight burst is dropped, including RAM writes not yet committed.
- Read latency: request accepted at edge N → beat issued in cycle N+1 → `r_valid` high after edge N+1. With `r_ready` held high, throughput is 1 beat/cycle.
- Write: the beat accepted in cycle N commits at edge N+1. `b_valid` is asserted from edge after last beat, earliest 1 cycle after the last beat handshake.
- `r_data`/`r_last` stay stable while `r_valid && !r_ready`.
- `req_len = 0`: single beat, `r_last = 1`.
- `req_len = 2^LEN_W-1`: full 2^LEN_W beats; `cnt` must not overflow.

## Structure
- Package `ram_burst_pkg`:
  - state enum
  - `BEAT_BYTES = 8`, `IDX_SHIFT = 3`
  - function `strb_to_mask(8b) → 64b`
- One natural sub-module: `ram_burst_rd_stage`, a 1-entry valid/ready output register holding `r_data`/`r_last` and exporting `can_load = !valid || ready`.

## Test plan
- Read burst, `req_addr = 0x1008`, `req_len = 3`, RAM preloaded with index k = k·0x11, `r_ready` = 1 → `ram_rIdx` 0x201..0x204; `r_data` 0x2211, 0x2222, 0x2233, 0x2244 on consecutive cycles; `r_last` only on the 4th.
- Same read with `r_ready` toggled 1,0,0,1… → no beat lost or duplicated; `r_data` stable while stalled; `ram_en` is 0 on stalled cycles.
- Write burst, `addr = 0x40`, `len = 1`, `w_strb = 0x0F` then 0xFF → `ram_wmask` 0x00000000FFFFFFFF then all ones; `ram_wIdx` 0x8, 0x9; `b_valid` is held until `b_ready`, then `req_ready` = 1.
- Back-to-back: 1-beat read left unconsumed, then a new 2-beat read is accepted → the first beat of the new burst appears only after the old beat is taken.
- `rst_n` pulsed low mid write burst (after beat 2 of 4) → all outputs at reset values immediately; no further `ram_wen`; the next request starts cleanly.
- Index wrap: `req_addr = 0xFFFF_FFFF_FFFF_FFF8`, `len = 1` → `ram_rIdx` 0x1FFF_FFFF_FFFF_FFFF, then 0x2000_0000_0000_0000 (`idx` is 64-bit; no truncation).
